// File: rtl/mem_arbiter_fsm.sv
// Registered arbiter sharing one single-ported RAM between instruction fetch and data access.
// Optional access timeout: define MEM_TIMEOUT_EN to abort grants stuck on busy_o.
module mem_arbiter_fsm #(
    parameter int unsigned MAX_DSTREAK    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemRen,
    input  logic [31:0] imemaddr,
    input  logic        dmmRen,
    input  logic        dmmWen,
    input  logic [31:0] dmmaddr,
    input  logic [31:0] dmmstore,
    input  logic        busy_o,
    input  logic [31:0] ramload,
    output logic        Ren,
    output logic        Wen,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic [31:0] imemload,
    output logic [31:0] dmmload,
    output logic        i_ready,
    output logic        d_ready,
    output logic        timeout_err
);

    localparam int unsigned     SW         = $clog2(MAX_DSTREAK + 2);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_DSTREAK);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("mem_arbiter_fsm: TIMEOUT_CYCLES must be nonzero");
    end

    typedef enum logic [1:0] {IDLE, IGNT, DGNT, DONE} state_t;

    state_t         state, state_next;
    logic [31:0]    lat_addr;
    logic [31:0]    lat_store;
    logic           lat_wr;
    logic           lat_data;
    logic [SW-1:0]  streak;
    logic           grant_data;
    logic           grant_fetch;
    logic           capture;
    logic           in_access;

    assign in_access = (state == IGNT) || (state == DGNT);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned     TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0]  tcount;
    logic           timed_out;

    assign timed_out = in_access && busy_o && (tcount == T_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            tcount      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (grant_data || grant_fetch) begin
                tcount <= '0;
            end else if (in_access && busy_o) begin
                tcount <= tcount + 1'b1;
            end
            if (timed_out) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            lat_addr  <= '0;
            lat_store <= '0;
            lat_wr    <= 1'b0;
            lat_data  <= 1'b0;
            streak    <= '0;
            imemload  <= '0;
            dmmload   <= '0;
        end else begin
            state <= state_next;
            // Reads latch a zero store word so the grant states can drive ramstore directly.
            if (grant_data) begin
                lat_addr  <= dmmaddr;
                lat_wr    <= !dmmRen;
                lat_store <= dmmRen ? '0 : dmmstore;
                lat_data  <= 1'b1;
                if (!imemRen) begin
                    streak <= '0;
                end else if (streak != STREAK_MAX) begin
                    streak <= streak + 1'b1;
                end
            end else if (grant_fetch) begin
                lat_addr  <= imemaddr;
                lat_wr    <= 1'b0;
                lat_store <= '0;
                lat_data  <= 1'b0;
                streak    <= '0;
            end
            if (capture) begin
                if (!lat_data) begin
                    imemload <= ramload;
                end else if (!lat_wr) begin
                    dmmload <= ramload;
                end
            end
        end
    end

    always_comb begin
        state_next  = state;
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        capture     = 1'b0;
        Ren         = 1'b0;
        Wen         = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        i_ready     = 1'b0;
        d_ready     = 1'b0;
        case (state)
            IDLE: begin
                if ((dmmRen || dmmWen) && !(imemRen && (streak == STREAK_MAX))) begin
                    grant_data = 1'b1;
                    state_next = DGNT;
                end else if (imemRen) begin
                    grant_fetch = 1'b1;
                    state_next  = IGNT;
                end
            end
            IGNT, DGNT: begin
                Ren      = !lat_wr;
                Wen      = lat_wr;
                ramaddr  = lat_addr;
                ramstore = lat_store;
                if (!busy_o) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timed_out) begin
                    state_next = DONE;
                end
`endif
            end
            DONE: begin
                i_ready    = !lat_data;
                d_ready    = lat_data;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter_fsm.sv
// Self-checking bench for mem_arbiter_fsm: vector table, corner sequences, randomized model check.
// Timeout checks run when MEM_TIMEOUT_EN is defined; otherwise the wait-forever behaviour is checked.
module tb_mem_arbiter_fsm;

    localparam int unsigned MAXS = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemRen, dmmRen, dmmWen, busy_o;
    logic [31:0] imemaddr, dmmaddr, dmmstore, ramload;
    logic        Ren, Wen, i_ready, d_ready, timeout_err;
    logic [31:0] ramaddr, ramstore, imemload, dmmload;

    int tests  = 0;
    int failed = 0;

    mem_arbiter_fsm #(.MAX_DSTREAK(MAXS), .TIMEOUT_CYCLES(8)) dut (
        .CLK(CLK), .RST(RST),
        .imemRen(imemRen), .imemaddr(imemaddr),
        .dmmRen(dmmRen), .dmmWen(dmmWen), .dmmaddr(dmmaddr), .dmmstore(dmmstore),
        .busy_o(busy_o), .ramload(ramload),
        .Ren(Ren), .Wen(Wen), .ramaddr(ramaddr), .ramstore(ramstore),
        .imemload(imemload), .dmmload(dmmload),
        .i_ready(i_ready), .d_ready(d_ready), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        ir, dr, dw, busy;
        logic [31:0] ia, da, ds, rl;
        logic        eren, ewen, eiry, edry;
        logic [31:0] eaddr, estore, eiload, edload;
    } vec_t;

    function automatic vec_t v(logic ir, logic dr, logic dw, logic busy,
                               logic [31:0] ia, logic [31:0] da, logic [31:0] ds, logic [31:0] rl,
                               logic eren, logic ewen, logic eiry, logic edry,
                               logic [31:0] eaddr, logic [31:0] estore,
                               logic [31:0] eiload, logic [31:0] edload);
        vec_t r;
        r.ir = ir; r.dr = dr; r.dw = dw; r.busy = busy;
        r.ia = ia; r.da = da; r.ds = ds; r.rl = rl;
        r.eren = eren; r.ewen = ewen; r.eiry = eiry; r.edry = edry;
        r.eaddr = eaddr; r.estore = estore; r.eiload = eiload; r.edload = edload;
        return r;
    endfunction

    function automatic logic [132:0] act_outs();
        return {Ren, Wen, i_ready, d_ready, timeout_err, ramaddr, ramstore, imemload, dmmload};
    endfunction

    task automatic chk(input string name, input logic [132:0] act, input logic [132:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_in();
        imemRen = 0; dmmRen = 0; dmmWen = 0; busy_o = 0;
        imemaddr = '0; dmmaddr = '0; dmmstore = '0; ramload = '0;
    endtask

    task automatic do_reset();
        clear_in();
        RST = 1;
        tick();
        tick();
        RST = 0;
    endtask

    // Transaction-level reference: one access in flight, then one ready cycle, then idle.
    bit          m_acc, m_data, m_wr;
    int          m_ready;
    int unsigned m_streak;
    logic [31:0] m_addr, m_store, m_iload, m_dload;

    function automatic logic [132:0] model_outs();
        return {m_acc && !m_wr, m_acc && m_wr, m_ready == 1, m_ready == 2, 1'b0,
                m_acc ? m_addr : 32'h0, m_acc ? m_store : 32'h0, m_iload, m_dload};
    endfunction

    task automatic model_step();
        if (m_ready != 0) begin
            m_ready = 0;
        end else if (m_acc) begin
            if (!busy_o) begin
                if (!m_data) m_iload = ramload;
                else if (!m_wr) m_dload = ramload;
                m_ready = m_data ? 2 : 1;
                m_acc   = 0;
            end
        end else if ((dmmRen || dmmWen) && !(imemRen && m_streak == MAXS)) begin
            m_acc = 1; m_data = 1; m_wr = !dmmRen;
            m_addr = dmmaddr; m_store = dmmRen ? 32'h0 : dmmstore;
            m_streak = imemRen ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
        end else if (imemRen) begin
            m_acc = 1; m_data = 0; m_wr = 0;
            m_addr = imemaddr; m_store = 32'h0; m_streak = 0;
        end
    endtask

    vec_t vecs[$];

    initial begin
        int dcnt, rounds;
        int unsigned run;

        // Reset with no requests: everything quiet.
        clear_in();
        RST = 1;
        tick();
        chk("reset_c1", act_outs(), '0);
        tick();
        chk("reset_c2", act_outs(), '0);
        RST = 0;

        // Each row: inputs for the cycle, outputs expected during that same cycle.
        vecs.push_back(v(1,0,0,0, 32'h100,0,0,0,                 0,0,0,0, 0,0, 0,0));
        vecs.push_back(v(1,0,0,0, 32'h100,0,0,32'hCAFE0001,      1,0,0,0, 32'h100,0, 0,0));
        vecs.push_back(v(0,0,0,0, 0,0,0,0,                       0,0,1,0, 0,0, 32'hCAFE0001,0));
        vecs.push_back(v(1,1,0,0, 32'h104,32'h200,32'h77,0,      0,0,0,0, 0,0, 32'hCAFE0001,0));
        vecs.push_back(v(1,1,0,0, 32'h104,32'h200,32'h77,32'hD00D0002, 1,0,0,0, 32'h200,0, 32'hCAFE0001,0));
        vecs.push_back(v(1,0,0,0, 32'h104,0,0,0,                 0,0,0,1, 0,0, 32'hCAFE0001,32'hD00D0002));
        vecs.push_back(v(1,0,0,0, 32'h104,0,0,0,                 0,0,0,0, 0,0, 32'hCAFE0001,32'hD00D0002));
        vecs.push_back(v(1,0,0,1, 32'h999,0,0,32'hDEAD,          1,0,0,0, 32'h104,0, 32'hCAFE0001,32'hD00D0002));
        vecs.push_back(v(1,0,0,0, 32'h999,0,0,32'hCAFE0002,      1,0,0,0, 32'h104,0, 32'hCAFE0001,32'hD00D0002));
        vecs.push_back(v(0,0,0,0, 0,0,0,0,                       0,0,1,0, 0,0, 32'hCAFE0002,32'hD00D0002));
        vecs.push_back(v(0,1,1,0, 0,32'h300,32'h1234,0,          0,0,0,0, 0,0, 32'hCAFE0002,32'hD00D0002));
        vecs.push_back(v(0,1,1,0, 0,32'h300,32'h1234,32'hBEEF0003, 1,0,0,0, 32'h300,0, 32'hCAFE0002,32'hD00D0002));
        vecs.push_back(v(0,0,0,0, 0,0,0,0,                       0,0,0,1, 0,0, 32'hCAFE0002,32'hBEEF0003));
        vecs.push_back(v(0,0,1,0, 0,32'h44,32'hA5A5,0,           0,0,0,0, 0,0, 32'hCAFE0002,32'hBEEF0003));
        vecs.push_back(v(0,0,1,0, 0,32'h44,32'hA5A5,32'hFFFF,    0,1,0,0, 32'h44,32'hA5A5, 32'hCAFE0002,32'hBEEF0003));
        vecs.push_back(v(0,0,0,0, 0,0,0,0,                       0,0,0,1, 0,0, 32'hCAFE0002,32'hBEEF0003));

        foreach (vecs[i]) begin
            imemRen = vecs[i].ir; dmmRen = vecs[i].dr; dmmWen = vecs[i].dw; busy_o = vecs[i].busy;
            imemaddr = vecs[i].ia; dmmaddr = vecs[i].da; dmmstore = vecs[i].ds; ramload = vecs[i].rl;
            chk($sformatf("vec%0d", i), act_outs(),
                {vecs[i].eren, vecs[i].ewen, vecs[i].eiry, vecs[i].edry, 1'b0,
                 vecs[i].eaddr, vecs[i].estore, vecs[i].eiload, vecs[i].edload});
            tick();
        end

        // Held data writes plus held fetch: MAXS data grants, then one fetch, twice over.
        do_reset();
        imemRen = 1; imemaddr = 32'h800; dmmWen = 1; dmmaddr = 32'h900; dmmstore = 32'h1;
        dcnt = 0;
        rounds = 0;
        for (int c = 0; c < 80 && rounds < 2; c++) begin
            tick();
            if (d_ready) dcnt++;
            if (i_ready) begin
                chk($sformatf("streak_round%0d", rounds), dcnt, MAXS);
                dcnt = 0;
                rounds++;
            end
        end
        chk("streak_rounds", rounds, 2);

        // Write held through 5 busy cycles; strobes come only from latched values.
        do_reset();
        dmmWen = 1; dmmaddr = 32'h40; dmmstore = 32'h55AA; busy_o = 1;
        tick();
        for (int k = 0; k < 5; k++) begin
            dmmaddr = $urandom; dmmstore = $urandom;
            chk($sformatf("wr_busy%0d", k), {Ren, Wen, d_ready, ramaddr, ramstore},
                {1'b0, 1'b1, 1'b0, 32'h40, 32'h55AA});
            tick();
        end
        busy_o = 0;
        chk("wr_last", {Ren, Wen, d_ready, ramaddr, ramstore}, {1'b0, 1'b1, 1'b0, 32'h40, 32'h55AA});
        tick();
        dmmWen = 0;
        chk("wr_ready", {Ren, Wen, d_ready, ramaddr, dmmload}, {1'b0, 1'b0, 1'b1, 32'h0, 32'h0});
        tick();
        chk("wr_ready_once", act_outs(), '0);

        // Reset in the third busy cycle aborts the write without a ready pulse.
        do_reset();
        dmmWen = 1; dmmaddr = 32'h40; dmmstore = 32'h55AA; busy_o = 1;
        tick();
        tick();
        tick();
        chk("abort_pre", {Wen, ramaddr}, {1'b1, 32'h40});
        RST = 1;
        tick();
        chk("abort_rst", act_outs(), '0);
        RST = 0; dmmWen = 0; busy_o = 0;
        tick();
        chk("abort_no_ready", act_outs(), '0);

        // Randomized traffic against the reference model; busy runs kept short of the timeout.
        do_reset();
        m_acc = 0; m_data = 0; m_wr = 0; m_ready = 0; m_streak = 0;
        m_addr = '0; m_store = '0; m_iload = '0; m_dload = '0;
        run = 0;
        for (int c = 0; c < 600; c++) begin
            imemRen = ($urandom_range(0, 3) != 0);
            dmmRen  = ($urandom_range(0, 2) == 0);
            dmmWen  = ($urandom_range(0, 2) == 0);
            imemaddr = $urandom; dmmaddr = $urandom; dmmstore = $urandom; ramload = $urandom;
            busy_o = (run < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
            run = busy_o ? run + 1 : 0;
            chk($sformatf("rand%0d", c), act_outs(), model_outs());
            model_step();
            tick();
        end

        // Fetch with busy_o stuck high.
        do_reset();
        imemRen = 1; imemaddr = 32'h500; busy_o = 1; ramload = 32'h12345678;
        tick();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("stuck%0d", k), {Ren, i_ready, timeout_err, ramaddr}, {1'b1, 1'b0, 1'b0, 32'h500});
            tick();
        end
`ifdef MEM_TIMEOUT_EN
        imemRen = 0;
        chk("to_pulse", {Ren, i_ready, timeout_err, imemload}, {1'b0, 1'b1, 1'b1, 32'h0});
        tick();
        chk("to_once", {i_ready, timeout_err}, {1'b0, 1'b1});
        tick();
        tick();
        chk("to_sticky", {Ren, timeout_err}, {1'b0, 1'b1});
        do_reset();
        chk("to_cleared", timeout_err, 0);
`else
        chk("no_timeout", {Ren, i_ready, timeout_err}, {1'b1, 1'b0, 1'b0});
        ramload = 32'h600D;
        busy_o = 0;
        tick();
        imemRen = 0;
        chk("late_ready", {i_ready, timeout_err, imemload}, {1'b1, 1'b0, 32'h600D});
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
